cnt_capture_disp: RTL and testbench

- Downstream consumer of the 4-bit ripple-counter output q[3:0].
- That output is asynchronous to the system clock and glitches while bits ripple. This block synchronizes and stability-filters it, then accepts clean count values.
- It detects wraps and missed steps, keeps a BCD "tens" digit of wraps, and drives a 2-digit multiplexed active-low seven-segment display. Tens shows on the left digit, the hex count on the right.

---
 rtl/cnt_capture_disp_pkg.sv | 26 ++
 rtl/cnt_capture_disp_seg7_hex.sv | 34 +++
 rtl/cnt_capture_disp.sv | 115 +++++++++++
 tb/tb_cnt_capture_disp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_capture_disp_pkg.sv
// Shared constants for the ripple-count capture block: active-low seven-segment
// glyphs in {g,f,e,d,c,b,a} order and active-low digit enables.
package cnt_capture_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/cnt_capture_disp_seg7_hex.sv
// Purpose: 4-bit value to active-low seven-segment glyph (hex, lower-case b/d).
// Latency: combinational.
// Backpressure: none.
module seg7_hex
    import cnt_capture_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/cnt_capture_disp.sv
// Purpose: synchronize, stability-filter and track a ripple counter; show tens/count on 2-digit 7-seg.
// Latency: settled cnt_in reaches value at edge STABLE_CYCLES+3; seg/an one cycle after value/tens.
// Backpressure: none; free-running capture, every accepted value is reported immediately.
module cnt_capture_disp
    import cnt_capture_disp_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int REFRESH_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt_in,
    input  logic       clr,
    output logic [3:0] value,
    output logic       upd,
    output logic       wrap,
    output logic [3:0] tens,
    output logic       skip,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);

    logic [3:0]              sync_1;
    logic [3:0]              sync_2;
    logic [3:0]              cand;
    logic [7:0]              stab_cnt;
    logic [REFRESH_BITS-1:0] refresh;
    logic [REFRESH_BITS-1:0] refresh_nxt;
    logic                    accept;
    logic                    is_wrap;
    logic                    disp_tens;
    logic [6:0]              glyph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 4'd0;
            sync_2 <= 4'd0;
        end else begin
            sync_1 <= cnt_in;
            sync_2 <= sync_1;
        end
    end

    // A candidate is accepted once it has been seen STABLE_CYCLES+1 times in a row.
    assign accept  = (sync_2 == cand) && (stab_cnt == STAB_MAX) && (cand != value);
    assign is_wrap = accept && (cand < value);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand     <= 4'd0;
            stab_cnt <= 8'd0;
        end else if (sync_2 != cand) begin
            cand     <= sync_2;
            stab_cnt <= 8'd0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 4'd0;
            upd   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            upd  <= accept;
            wrap <= is_wrap;
            if (accept) begin
                value <= cand;
            end
        end
    end

    // clr has priority over a coincident accept for the wrap/skip bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 4'd0;
            skip <= 1'b0;
        end else if (clr) begin
            tens <= 4'd0;
            skip <= 1'b0;
        end else begin
            if (is_wrap) begin
                tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end
            if (accept && (cand != value + 4'd1)) begin
                skip <= 1'b1;
            end
        end
    end

    // Digit select follows the next refresh value so seg/an switch on the MSB edge.
    assign refresh_nxt = refresh + 1'b1;
    assign disp_tens   = refresh_nxt[REFRESH_BITS-1];

    seg7_hex u_seg7_hex (
        .digit (disp_tens ? tens : value),
        .seg   (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh <= '0;
            seg     <= SEG_0;
            an      <= AN_UNITS;
        end else begin
            refresh <= refresh_nxt;
            seg     <= glyph;
            an      <= disp_tens ? AN_TENS : AN_UNITS;
        end
    end

endmodule

// File: tb/tb_cnt_capture_disp.sv
// Bench for cnt_capture_disp: directed scenarios plus random cnt_in/clr traffic,
// checked every cycle against a window-based reference model.
module tb_cnt_capture_disp;

    localparam int STABLE = 4;
    localparam int RB     = 4;
    localparam int HLEN   = STABLE + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] cnt_in;
    logic [3:0] value;
    logic       upd;
    logic       wrap;
    logic [3:0] tens;
    logic       skip;
    logic [6:0] seg;
    logic [1:0] an;

    cnt_capture_disp #(
        .STABLE_CYCLES (STABLE),
        .REFRESH_BITS  (RB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cnt_in (cnt_in),
        .clr    (clr),
        .value  (value),
        .upd    (upd),
        .wrap   (wrap),
        .tens   (tens),
        .skip   (skip),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    // reference model state
    int         hist [HLEN];
    int         mval, mtens, mskip, mupd, mwrap, mrc;
    logic [1:0] man;
    logic [6:0] mseg;
    int         wraps_seen, upds_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:  glyph = 7'b1000000;
            1:  glyph = 7'b1111001;
            2:  glyph = 7'b0100100;
            3:  glyph = 7'b0110000;
            4:  glyph = 7'b0011001;
            5:  glyph = 7'b0010010;
            6:  glyph = 7'b0000010;
            7:  glyph = 7'b1111000;
            8:  glyph = 7'b0000000;
            9:  glyph = 7'b0010000;
            10: glyph = 7'b0001000;
            11: glyph = 7'b0000011;
            12: glyph = 7'b1000110;
            13: glyph = 7'b0100001;
            14: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HLEN; i++) hist[i] = 0;
        mval = 0; mtens = 0; mskip = 0; mupd = 0; mwrap = 0; mrc = 0;
        man  = 2'b10;
        mseg = 7'b1000000;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_value"}, value, 0);
        chk({tag, "_upd"},   upd,   0);
        chk({tag, "_wrap"},  wrap,  0);
        chk({tag, "_tens"},  tens,  0);
        chk({tag, "_skip"},  skip,  0);
        chk({tag, "_seg"},   seg,   7'b1000000);
        chk({tag, "_an"},    an,    2'b10);
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic tick();
        bit stable;
        bit acc;
        int v;
        @(posedge clk);
        for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(cnt_in);
        mrc = (mrc + 1) % (1 << RB);
        if (mrc >= (1 << (RB - 1))) begin
            man  = 2'b01;
            mseg = glyph(mtens);
        end else begin
            man  = 2'b10;
            mseg = glyph(mval);
        end
        // value seen by the filter this edge is cnt_in from two edges back
        v = hist[2];
        stable = 1'b1;
        for (int i = 3; i < HLEN; i++) if (hist[i] != v) stable = 1'b0;
        acc   = stable && (v != mval);
        mupd  = acc ? 1 : 0;
        mwrap = (acc && v < mval) ? 1 : 0;
        if (clr) begin
            mtens = 0;
            mskip = 0;
        end else begin
            if (mwrap == 1) mtens = (mtens + 1) % 10;
            if (acc && v != (mval + 1) % 16) mskip = 1;
        end
        if (acc) mval = v;
        #1;
        chk("value", value, mval);
        chk("upd",   upd,   mupd);
        chk("wrap",  wrap,  mwrap);
        chk("tens",  tens,  mtens);
        chk("skip",  skip,  mskip);
        chk("seg",   seg,   mseg);
        chk("an",    an,    man);
        if (wrap) wraps_seen++;
        if (upd)  upds_seen++;
    endtask

    task automatic hold(input int v, input int n);
        cnt_in = 4'(v);
        repeat (n) tick();
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs({tag, "_held"});
        cnt_in = 4'd0;
        rst    = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        cnt_in = 4'd0;
        wraps_seen = 0;
        upds_seen  = 0;
        model_reset();
        async_reset("rst0");

        // latency: 0 -> 1 lands exactly at edge STABLE+3
        hold(0, 10);
        cnt_in = 4'd1;
        repeat (STABLE + 2) tick();
        chk("lat_pre_value", value, 0);
        tick();
        chk("lat_value", value, 1);
        chk("lat_upd", upd, 1);
        tick();
        chk("lat_upd_low", upd, 0);
        chk("lat_skip", skip, 0);

        // glitch reject: 7 -> short 0 -> 8
        hold(7, 10);
        wraps_seen = 0;
        upds_seen  = 0;
        hold(0, 3);
        hold(8, 10);
        chk("glitch_value", value, 8);
        chk("glitch_upds", upds_seen, 1);
        chk("glitch_wraps", wraps_seen, 0);

        // sixteen full wraps from a cleared state
        hold(0, 8);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_tens", tens, 0);
        chk("clr_skip", skip, 0);
        wraps_seen = 0;
        for (int r = 0; r < 16; r++) begin
            for (int v = 1; v < 16; v++) hold(v, 6);
            hold(0, 6);
        end
        hold(0, 4);
        chk("wrap_count", wraps_seen, 16);
        chk("wrap_tens", tens, 6);
        chk("wrap_skip", skip, 0);

        // skip on 3 -> 1, then clr coincident with a 15 -> 0 accept
        hold(3, 8);
        wraps_seen = 0;
        hold(1, 8);
        chk("skip_value", value, 1);
        chk("skip_flag", skip, 1);
        chk("skip_tens", tens, 7);
        chk("skip_wraps", wraps_seen, 1);
        hold(15, 8);
        cnt_in = 4'd0;
        repeat (STABLE + 2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrhit_value", value, 0);
        chk("clrhit_upd", upd, 1);
        chk("clrhit_wrap", wrap, 1);
        chk("clrhit_tens", tens, 0);
        chk("clrhit_skip", skip, 0);
        tick();
        chk("clrhit_wrap_low", wrap, 0);

        // display mux with value A and tens 3
        for (int k = 0; k < 3; k++) begin
            hold(5, 8);
            hold(2, 8);
        end
        hold(10, 8);
        chk("disp_tens", tens, 3);
        chk("disp_value", value, 10);
        for (int k = 0; k < 32; k++) begin
            tick();
            if (an == 2'b10) chk("disp_units_seg", seg, 7'b0001000);
            else             chk("disp_tens_seg",  seg, 7'b0110000);
        end

        // random traffic including short glitches, clr pulses and one mid-run reset
        for (int it = 0; it < 400; it++) begin
            int n;
            if (it == 200) async_reset("rst_mid");
            cnt_in = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 8);
            clr = ($urandom_range(0, 15) == 0);
            tick();
            clr = 1'b0;
            repeat (n - 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
